// File: rtl/io_bus_responder_if.sv
// CPU I/O bus between the address/data mux (master) and the peripheral responder (slave).
interface io_bus_responder_if;
  logic        ioRead;
  logic        ioWrite;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic        LEDCtrl;
  logic        SwitchCtrl;
  logic        CUBECtrl;
  logic [15:0] io_rdata;

  modport master (
    output ioRead, ioWrite, addr, write_data, LEDCtrl, SwitchCtrl, CUBECtrl,
    input  io_rdata
  );

  modport slave (
    input  ioRead, ioWrite, addr, write_data, LEDCtrl, SwitchCtrl, CUBECtrl,
    output io_rdata
  );
endinterface

// File: rtl/io_bus_responder.sv
// MMIO responder: LED/7-seg registers, synchronised switches, free-running 8-digit scan.
// Define IO_DEBOUNCE_EN to add a DEB_CYCLES hold-time filter on the switch inputs.
module io_bus_responder #(
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEB_CYCLES = 1000000
) (
  input  logic                clock,
  input  logic                reset,
  io_bus_responder_if.slave   bus,
  input  logic [23:0]         switch_i,
  output logic [23:0]         led_o,
  output logic [7:0]          seg_en,
  output logic [7:0]          seg_out
);
  localparam logic [31:0] LED_ADDR = 32'hFFFFFC60;
  localparam logic [31:0] SW_ADDR  = 32'hFFFFFC70;
  localparam logic [31:0] SEG_ADDR = 32'hFFFFFC80;
  localparam int unsigned SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [7:0][3:0]   seg_digits;
  logic [23:0]       sw_s1, sw_s2, sw_q;
  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        dig_idx;
  logic              scan_on;
  logic              scan_tick;
  logic              hit_led, hit_sw, hit_seg, hi;
  logic              unused_bits;

  // addr[0] is don't-care; only the low halfword of write_data is ever used
  assign unused_bits = ^{bus.addr[0], bus.write_data[31:16]};

  assign hi      = bus.addr[1];
  assign hit_led = (bus.addr[31:2] == LED_ADDR[31:2]) && bus.LEDCtrl;
  assign hit_sw  = (bus.addr[31:2] == SW_ADDR[31:2])  && bus.SwitchCtrl;
  assign hit_seg = (bus.addr[31:2] == SEG_ADDR[31:2]) && bus.CUBECtrl;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_o      <= '0;
      seg_digits <= '0;
    end else if (bus.ioWrite) begin
      if (hit_led) begin
        if (hi) led_o[23:16] <= bus.write_data[7:0];
        else    led_o[15:0]  <= bus.write_data[15:0];
      end
      if (hit_seg) begin
        if (hi) seg_digits[7:4] <= bus.write_data[15:0];
        else    seg_digits[3:0] <= bus.write_data[15:0];
      end
    end
  end

  // Reads see registered state only, so a same-cycle write shows up next cycle.
  always_comb begin
    bus.io_rdata = 16'h0000;
    if (bus.ioRead) begin
      if (hit_led)      bus.io_rdata = hi ? {8'h00, led_o[23:16]} : led_o[15:0];
      else if (hit_sw)  bus.io_rdata = hi ? {8'h00, sw_q[23:16]}  : sw_q[15:0];
      else if (hit_seg) bus.io_rdata = hi ? seg_digits[7:4]       : seg_digits[3:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch_i;
      sw_s2 <= sw_s1;
    end
  end

`ifdef IO_DEBOUNCE_EN
  localparam int unsigned DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  logic [DEB_W-1:0] deb_cnt;

  // One shared counter: any bit differing restarts the hold window on return to equality.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      deb_cnt <= '0;
      sw_q    <= '0;
    end else if (sw_s2 == sw_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      sw_q    <= sw_s2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end
`else
  localparam int unsigned UNUSED_DEB_CYCLES = DEB_CYCLES;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sw_q <= '0;
    else       sw_q <= sw_s2;
  end
`endif

  assign scan_tick = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

  // First tick only un-blanks the display on digit 0; later ticks advance the digit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      dig_idx  <= '0;
      scan_on  <= 1'b0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 1'b1;
      if (scan_tick) begin
        scan_on <= 1'b1;
        if (scan_on) dig_idx <= dig_idx + 1'b1;
      end
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    seg_en  = 8'hFF;
    seg_out = 8'hFF;
    if (scan_on) begin
      seg_en  = ~(8'b1 << dig_idx);
      seg_out = {1'b1, hex7(seg_digits[dig_idx])};
    end
  end
endmodule

// File: tb/tb_io_bus_responder.sv
// Directed bench for io_bus_responder (SCAN_DIV=4, DEB_CYCLES=8); inputs change on negedges.
module tb_io_bus_responder;
  localparam int SCAN_DIV   = 4;
  localparam int DEB_CYCLES = 8;
`ifdef IO_DEBOUNCE_EN
  localparam int SW_LAT = 2 + DEB_CYCLES;
`else
  localparam int SW_LAT = 3;
`endif
  localparam logic [31:0] A_LED_LO = 32'hFFFFFC60, A_LED_HI = 32'hFFFFFC62;
  localparam logic [31:0] A_SW_LO  = 32'hFFFFFC70, A_SW_HI  = 32'hFFFFFC72;
  localparam logic [31:0] A_SEG_LO = 32'hFFFFFC80, A_SEG_HI = 32'hFFFFFC82;
  localparam logic [2:0]  CS_LED = 3'b001, CS_SW = 3'b010, CS_SEG = 3'b100;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] switch_i, led_o;
  logic [7:0]  seg_en, seg_out;
  int          n_chk = 0, n_pass = 0;

  io_bus_responder_if bus();

  io_bus_responder #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .switch_i(switch_i), .led_o(led_o), .seg_en(seg_en), .seg_out(seg_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, exp);
  endtask

  task automatic set_cs(input logic [2:0] cs);
    bus.LEDCtrl    = cs[0];
    bus.SwitchCtrl = cs[1];
    bus.CUBECtrl   = cs[2];
  endtask

  task automatic bus_idle();
    bus.ioRead = 1'b0; bus.ioWrite = 1'b0;
    bus.addr = '0; bus.write_data = '0;
    set_cs(3'b000);
  endtask

  // One write, consumes exactly one rising edge; upper data bits carry junk.
  task automatic bus_write(input logic [31:0] a, input logic [15:0] d, input logic [2:0] cs);
    bus.addr = a; bus.write_data = {16'hDEAD, d}; set_cs(cs); bus.ioWrite = 1'b1;
    @(negedge clock);
    bus_idle();
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [2:0] cs,
                        input logic [15:0] exp);
    bus.addr = a; set_cs(cs); bus.ioRead = 1'b1;
    #1 chk(tag, bus.io_rdata, exp);
    bus_idle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: timeout, got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] seg_pat [8];
    logic [7:0] exp_en;
    logic       found;
    int         d;
    seg_pat = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};

    reset = 1'b1; switch_i = '0; bus_idle();
    repeat (2) @(negedge clock);
    chk("rst_led", led_o, 24'h0);
    chk("rst_seg_en", seg_en, 8'hFF);
    chk("rst_seg_out", seg_out, 8'hFF);
    rd_chk("rst_rd_led", A_LED_LO, CS_LED, 16'h0000);

    // scan: release at a negedge, so the next rising edge is edge 1
    @(negedge clock); reset = 1'b0;
    bus_write(A_SEG_LO, 16'h3210, CS_SEG);
    bus_write(A_SEG_HI, 16'h7654, CS_SEG);
    chk("blank_e2", seg_en, 8'hFF);
    rd_chk("rd_seg_lo", A_SEG_LO, CS_SEG, 16'h3210);
    rd_chk("rd_seg_hi", A_SEG_HI, CS_SEG, 16'h7654);
    @(negedge clock);
    chk("blank_e3", seg_en, 8'hFF);
    chk("blank_out_e3", seg_out, 8'hFF);
    for (int e = 4; e <= 36; e++) begin
      @(negedge clock);
      d = ((e - 4) / 4) % 8;
      exp_en = ~(8'b1 << d);
      chk($sformatf("scan_en_e%0d", e), seg_en, exp_en);
      chk($sformatf("scan_out_e%0d", e), seg_out, seg_pat[d]);
    end

    // LED registers
    bus_write(A_LED_LO, 16'h1234, CS_LED);
    bus_write(A_LED_HI, 16'h77AB, CS_LED);
    chk("led_write", led_o, 24'hAB1234);
    rd_chk("rd_led_lo", A_LED_LO, CS_LED, 16'h1234);
    rd_chk("rd_led_hi", A_LED_HI, CS_LED, 16'h00AB);
    rd_chk("rd_led_a0", 32'hFFFFFC61, CS_LED, 16'h1234);

    bus.addr = A_LED_LO; bus.write_data = 32'h0000_5555; set_cs(CS_LED);
    bus.ioRead = 1'b1; bus.ioWrite = 1'b1;
    #1 chk("rw_same_old", bus.io_rdata, 16'h1234);
    @(negedge clock); bus_idle();
    chk("rw_same_led", led_o, 24'hAB5555);
    rd_chk("rw_same_new", A_LED_LO, CS_LED, 16'h5555);

    bus_write(A_LED_LO, 16'hFFFF, 3'b000);
    chk("wr_no_cs", led_o, 24'hAB5555);
    bus_write(A_LED_LO, 16'hFFFF, CS_SW | CS_SEG);
    chk("wr_wrong_cs", led_o, 24'hAB5555);
    bus_write(A_SW_LO, 16'hBEEF, CS_SW);
    rd_chk("wr_sw_ignored", A_SW_LO, CS_SW, 16'h0000);
    chk("wr_sw_led", led_o, 24'hAB5555);
    rd_chk("rd_unmapped", 32'hFFFFFC90, 3'b111, 16'h0000);
    rd_chk("rd_no_cs", A_LED_LO, 3'b000, 16'h0000);

`ifdef IO_DEBOUNCE_EN
    switch_i = 24'h000001;
    repeat (5) @(negedge clock);
    switch_i = 24'h000000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      rd_chk($sformatf("glitch_%0d", i), A_SW_LO, CS_SW, 16'h0000);
    end
`endif

    // switch latency, checked on every cycle around the boundary
    switch_i = 24'h00F00F;
    for (int k = 1; k <= SW_LAT + 2; k++) begin
      @(negedge clock);
      rd_chk($sformatf("sw_lat_%0d", k), A_SW_LO, CS_SW, (k >= SW_LAT) ? 16'hF00F : 16'h0000);
    end
    switch_i = 24'h5AF00F;
    repeat (SW_LAT + 1) @(negedge clock);
    rd_chk("rd_sw_hi", A_SW_HI, CS_SW, 16'h005A);

    // reset mid-scan at digit 5
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    bus_write(A_LED_LO, 16'h00FF, CS_LED);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clock);
      if (seg_en == 8'hDF) found = 1'b1;
    end
    chk("reach_dig5", found, 1'b1);
    chk("led_before_rst", led_o, 24'h0000FF);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_led", led_o, 24'h0);
    chk("mid_rst_seg_en", seg_en, 8'hFF);
    chk("mid_rst_seg_out", seg_out, 8'hFF);
    rd_chk("mid_rst_seg_reg", A_SEG_LO, CS_SEG, 16'h0000);
    rd_chk("mid_rst_sw", A_SW_HI, CS_SW, 16'h0000);
    @(negedge clock); reset = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clock);
      chk($sformatf("rel_en_e%0d", e), seg_en, (e < 4) ? 8'hFF : 8'hFE);
    end
    chk("rel_out_e4", seg_out, 8'hC0);
    chk("rel_led", led_o, 24'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
